// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared types and constants for the ADC scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

   localparam int DATA_W      = 16;
   localparam int WINLOG2_MIN = 1;
   localparam int WINLOG2_MAX = 10;
   localparam int PAIR_CNT_W  = 11;
   localparam int TMR_W       = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_START  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_SETTLE = 2'd3
   } adc_state_e;

   function automatic logic [3:0] clamp_winlog2(input logic [3:0] w);
      logic [3:0] r;
      r = w;
      if (w < 4'(WINLOG2_MIN)) r = 4'(WINLOG2_MIN);
      if (w > 4'(WINLOG2_MAX)) r = 4'(WINLOG2_MAX);
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adc_cyc_timer.sv
`default_nettype none
// ============================================================================
// Module      : adc_cyc_timer
// Description : Loadable down-counter that stops at zero and flags it.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_cyc_timer
   import adc_pkg::*;
#(
   parameter int WIDTH = TMR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/adc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_seq_ctrl
// Description : Two-channel ADC scan sequencer with windowed pair counting.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_seq_ctrl
   import adc_pkg::*;
#(
   parameter int SETTLE_CYC  = 8,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [3:0]        winlog2,
   input  logic              adc_done,
   input  logic [DATA_W-1:0] adc_data,
   output logic              adc_start,
   output logic              adc_ch,
   output logic [DATA_W-1:0] adc1dat,
   output logic [DATA_W-1:0] adc2dat,
   output logic              dat_vld,
   output logic              win_done,
   output logic              busy,
   output logic              err
);

   localparam logic [TMR_W-1:0] SETTLE_LOAD  = (SETTLE_CYC > 0)  ? TMR_W'(SETTLE_CYC - 1)  : '0;
   localparam logic [TMR_W-1:0] TIMEOUT_LOAD = (TIMEOUT_CYC > 0) ? TMR_W'(TIMEOUT_CYC - 1) : '0;
   // A zero-length settle skips the SETTLE state entirely.
   localparam adc_state_e ST_AFTER_CAP = (SETTLE_CYC > 0) ? ST_SETTLE : ST_START;

   adc_state_e            state_q, state_d;
   logic                  adc_ch_q, adc_ch_d;
   logic [DATA_W-1:0]     hold_q, hold_d;
   logic [DATA_W-1:0]     adc1dat_q, adc1dat_d;
   logic [DATA_W-1:0]     adc2dat_q, adc2dat_d;
   logic                  dat_vld_q, dat_vld_d;
   logic                  win_done_q, win_done_d;
   logic                  err_q, err_d;
   logic [PAIR_CNT_W-1:0] pair_cnt_q, pair_cnt_d;
   logic [3:0]            win_log2_q, win_log2_d;

   logic                  tmr_load;
   logic [TMR_W-1:0]      tmr_val;
   logic                  tmr_zero;
   logic [PAIR_CNT_W-1:0] win_mask;
   logic                  win_last;

   adc_cyc_timer #(.WIDTH(TMR_W)) u_tmr (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   assign win_mask = (PAIR_CNT_W'(1) << win_log2_q) - PAIR_CNT_W'(1);
   assign win_last = (pair_cnt_q == win_mask);

   always_comb begin
      state_d    = state_q;
      adc_ch_d   = adc_ch_q;
      hold_d     = hold_q;
      adc1dat_d  = adc1dat_q;
      adc2dat_d  = adc2dat_q;
      dat_vld_d  = 1'b0;
      win_done_d = 1'b0;
      err_d      = err_q;
      pair_cnt_d = pair_cnt_q;
      win_log2_d = win_log2_q;
      tmr_load   = 1'b0;
      tmr_val    = TIMEOUT_LOAD;

      case (state_q)
         ST_IDLE: begin
            adc_ch_d = 1'b0;
            if (en) begin
               win_log2_d = clamp_winlog2(winlog2);
               pair_cnt_d = '0;
               err_d      = 1'b0;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            tmr_load = 1'b1;
            tmr_val  = TIMEOUT_LOAD;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            // A done in the final timeout cycle wins over the timeout.
            if (adc_done) begin
               tmr_load = 1'b1;
               tmr_val  = SETTLE_LOAD;
               if (!adc_ch_q) begin
                  hold_d   = adc_data;
                  adc_ch_d = 1'b1;
                  state_d  = ST_AFTER_CAP;
               end else begin
                  adc1dat_d  = hold_q;
                  adc2dat_d  = adc_data;
                  dat_vld_d  = 1'b1;
                  win_done_d = win_last;
                  adc_ch_d   = 1'b0;
                  if (win_last) begin
                     pair_cnt_d = '0;
                     win_log2_d = clamp_winlog2(winlog2);
                  end else begin
                     pair_cnt_d = pair_cnt_q + PAIR_CNT_W'(1);
                  end
                  state_d = en ? ST_AFTER_CAP : ST_IDLE;
               end
            end else if (tmr_zero) begin
               err_d      = 1'b1;
               hold_d     = '0;
               pair_cnt_d = '0;
               adc_ch_d   = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (tmr_zero) begin
               state_d = ST_START;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         adc_ch_q   <= 1'b0;
         hold_q     <= '0;
         adc1dat_q  <= '0;
         adc2dat_q  <= '0;
         dat_vld_q  <= 1'b0;
         win_done_q <= 1'b0;
         err_q      <= 1'b0;
         pair_cnt_q <= '0;
         win_log2_q <= 4'(WINLOG2_MIN);
      end else begin
         state_q    <= state_d;
         adc_ch_q   <= adc_ch_d;
         hold_q     <= hold_d;
         adc1dat_q  <= adc1dat_d;
         adc2dat_q  <= adc2dat_d;
         dat_vld_q  <= dat_vld_d;
         win_done_q <= win_done_d;
         err_q      <= err_d;
         pair_cnt_q <= pair_cnt_d;
         win_log2_q <= win_log2_d;
      end
   end

   assign adc_start = (state_q == ST_START);
   assign busy      = (state_q != ST_IDLE);
   assign adc_ch    = adc_ch_q;
   assign adc1dat   = adc1dat_q;
   assign adc2dat   = adc2dat_q;
   assign dat_vld   = dat_vld_q;
   assign win_done  = win_done_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_seq_ctrl
// Description : Self-checking bench for adc_seq_ctrl with a converter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_seq_ctrl;

   localparam int SETTLE_CYC  = 8;
   localparam int TIMEOUT_CYC = 1023;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [3:0]  winlog2 = 4'd2;
   logic        adc_done;
   logic [15:0] adc_data;
   logic        adc_start, adc_ch, dat_vld, win_done, busy, err;
   logic [15:0] adc1dat, adc2dat;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [32:0] vld_log[$];    // {win_done, adc1dat, adc2dat}
   logic [16:0] conv_log[$];   // {channel at start, data returned}
   int          done_cyc[$];
   int          start_cyc[$];
   int          wide_start = 0;
   int          orphan_wd  = 0;

   bit          prev_start = 1'b0;
   bit          pend = 1'b0;
   int          pend_cnt = 0;
   logic        pend_ch = 1'b0;
   logic [15:0] pend_val = 16'h0;
   bit          silent = 1'b0;
   bit          rand_delay = 1'b0;
   bit          use_fixed = 1'b0;
   int          fixed_delay = 5;
   logic [15:0] fix1 = 16'h0;
   logic [15:0] fix2 = 16'h0;

   adc_seq_ctrl #(.SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .rst(rst), .en(en), .winlog2(winlog2),
      .adc_done(adc_done), .adc_data(adc_data),
      .adc_start(adc_start), .adc_ch(adc_ch),
      .adc1dat(adc1dat), .adc2dat(adc2dat),
      .dat_vld(dat_vld), .win_done(win_done), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Converter model and event recorder; done arrives d cycles after the start cycle.
   initial begin
      adc_done = 1'b0;
      adc_data = 16'h0;
      forever begin
         @(negedge clk);
         cyc++;
         if (dat_vld) vld_log.push_back({win_done, adc1dat, adc2dat});
         if (win_done && !dat_vld) orphan_wd++;
         if (adc_start) begin
            start_cyc.push_back(cyc);
            if (prev_start) wide_start++;
         end
         prev_start = adc_start;
         adc_done = 1'b0;
         adc_data = 16'($urandom);
         if (pend) begin
            if (pend_cnt <= 1) begin
               adc_done = 1'b1;
               adc_data = pend_val;
               pend = 1'b0;
               conv_log.push_back({pend_ch, pend_val});
               done_cyc.push_back(cyc);
            end else begin
               pend_cnt--;
            end
         end
         if (adc_start && !silent) begin
            pend     = 1'b1;
            pend_cnt = rand_delay ? int'($urandom_range(1, 12)) : fixed_delay;
            pend_ch  = adc_ch;
            pend_val = use_fixed ? (adc_ch ? fix2 : fix1) : 16'($urandom);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      vld_log.delete();
      conv_log.delete();
      done_cyc.delete();
      start_cyc.delete();
      wide_start = 0;
      orphan_wd  = 0;
   endtask

   function automatic int win_pairs(input int w);
      int c;
      c = (w < 1) ? 1 : ((w > 10) ? 10 : w);
      return 1 << c;
   endfunction

   task automatic test_reset();
      rst = 1'b1; en = 1'b0;
      repeat (3) tick();
      total++; if (adc_start !== 1'b0) begin bad++; $display("FAIL rst_adc_start: got %b want 0", adc_start); end
      total++; if (adc_ch !== 1'b0) begin bad++; $display("FAIL rst_adc_ch: got %b want 0", adc_ch); end
      total++; if (adc1dat !== 16'h0) begin bad++; $display("FAIL rst_adc1dat: got %h want 0000", adc1dat); end
      total++; if (adc2dat !== 16'h0) begin bad++; $display("FAIL rst_adc2dat: got %h want 0000", adc2dat); end
      total++; if (dat_vld !== 1'b0) begin bad++; $display("FAIL rst_dat_vld: got %b want 0", dat_vld); end
      total++; if (win_done !== 1'b0) begin bad++; $display("FAIL rst_win_done: got %b want 0", win_done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
      rst = 1'b0;
      repeat (3) tick();
      total++; if (busy !== 1'b0 || start_cyc.size() != 0) begin bad++; $display("FAIL idle_no_en: busy=%b starts=%0d want 0/0", busy, start_cyc.size()); end
   endtask

   task automatic test_window_basic();
      clear_logs();
      use_fixed = 1'b1; fix1 = 16'h0100; fix2 = 16'hFF00;
      rand_delay = 1'b0; fixed_delay = 5; silent = 1'b0;
      winlog2 = 4'd2; en = 1'b1;
      for (int i = 0; i < 2000 && vld_log.size() < 3; i++) tick();
      total++; if (vld_log.size() < 3) begin bad++; $display("FAIL win_wait: got %0d pulses want 3", vld_log.size()); end
      en = 1'b0;
      for (int i = 0; i < 500 && busy !== 1'b0; i++) tick();
      repeat (3) tick();
      total++; if (vld_log.size() != 4) begin bad++; $display("FAIL win_vld_count: got %0d want 4", vld_log.size()); end
      for (int j = 0; j < vld_log.size(); j++) begin
         logic [32:0] e;
         e = vld_log[j];
         total++; if (e[31:0] !== {16'h0100, 16'hFF00}) begin bad++; $display("FAIL win_pair%0d: got %h want 0100ff00", j, e[31:0]); end
         total++; if (e[32] !== (j == 3)) begin bad++; $display("FAIL win_done%0d: got %b want %b", j, e[32], (j == 3)); end
      end
      total++; if (orphan_wd != 0) begin bad++; $display("FAIL win_orphan: got %0d want 0", orphan_wd); end
      total++; if ({adc1dat, adc2dat} !== {16'h0100, 16'hFF00}) begin bad++; $display("FAIL win_hold: got %h%h want 0100ff00", adc1dat, adc2dat); end
      use_fixed = 1'b0;
   endtask

   task automatic test_settle();
      clear_logs();
      rand_delay = 1'b0; fixed_delay = 3; winlog2 = 4'd1; en = 1'b1;
      for (int i = 0; i < 500 && vld_log.size() < 1; i++) tick();
      en = 1'b0;
      for (int i = 0; i < 500 && busy !== 1'b0; i++) tick();
      repeat (3) tick();
      total++; if (start_cyc.size() != 4 || done_cyc.size() != 4) begin bad++; $display("FAIL settle_count: starts=%0d dones=%0d want 4/4", start_cyc.size(), done_cyc.size()); end
      for (int k = 0; k + 1 < start_cyc.size() && k < done_cyc.size(); k++) begin
         total++;
         if (start_cyc[k+1] - done_cyc[k] != SETTLE_CYC + 1) begin
            bad++; $display("FAIL settle_gap%0d: got %0d idle cycles want %0d", k, start_cyc[k+1] - done_cyc[k] - 1, SETTLE_CYC);
         end
      end
      total++; if (wide_start != 0) begin bad++; $display("FAIL settle_start_width: got %0d wide pulses want 0", wide_start); end
   endtask

   task automatic test_stop_after_ch1();
      logic [16:0] c0, c1;
      logic [32:0] e;
      clear_logs();
      rand_delay = 1'b0; fixed_delay = 4; winlog2 = 4'd3; en = 1'b1;
      for (int i = 0; i < 100 && conv_log.size() < 1; i++) tick();
      tick();
      en = 1'b0;
      for (int i = 0; i < 200 && busy !== 1'b0; i++) tick();
      repeat (40) tick();
      total++; if (start_cyc.size() != 2) begin bad++; $display("FAIL stop_starts: got %0d want 2", start_cyc.size()); end
      total++; if (vld_log.size() != 1) begin bad++; $display("FAIL stop_vld: got %0d want 1", vld_log.size()); end
      if (vld_log.size() > 0 && conv_log.size() > 1) begin
         e = vld_log[0]; c0 = conv_log[0]; c1 = conv_log[1];
         total++; if (e[31:0] !== {c0[15:0], c1[15:0]}) begin bad++; $display("FAIL stop_pair: got %h want %h%h", e[31:0], c0[15:0], c1[15:0]); end
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy: got %b want 0", busy); end
   endtask

   task automatic test_random_scan();
      for (int it = 0; it < 4; it++) begin
         int w1, w2, n1, n2, np, pos, ncur;
         w1 = (it == 0) ? 0 : ((it == 3) ? 12 : int'($urandom_range(1, 3)));
         w2 = int'($urandom_range(0, 3));
         n1 = win_pairs(w1); n2 = win_pairs(w2);
         np = int'($urandom_range(3, 12));
         clear_logs();
         rand_delay = 1'b1; use_fixed = 1'b0;
         winlog2 = 4'(w1); en = 1'b1;
         for (int i = 0; i < 50 && start_cyc.size() < 1; i++) tick();
         winlog2 = 4'(w2);
         for (int i = 0; i < 5000 && vld_log.size() < np - 1; i++) tick();
         en = 1'b0;
         for (int i = 0; i < 500 && busy !== 1'b0; i++) tick();
         repeat (3) tick();
         total++; if (vld_log.size() != np) begin bad++; $display("FAIL rnd%0d_vld_count: got %0d want %0d", it, vld_log.size(), np); end
         for (int k = 0; k < conv_log.size(); k++) begin
            logic [16:0] c;
            c = conv_log[k];
            total++; if (c[16] !== 1'(k % 2)) begin bad++; $display("FAIL rnd%0d_ch%0d: got %b want %0d", it, k, c[16], k % 2); end
         end
         pos = 0; ncur = n1;
         for (int j = 0; j < vld_log.size(); j++) begin
            logic [32:0] e;
            logic [16:0] a, b;
            bit exp_wd;
            e = vld_log[j];
            pos++;
            exp_wd = (pos == ncur);
            if (exp_wd) begin pos = 0; ncur = n2; end
            total++; if (e[32] !== exp_wd) begin bad++; $display("FAIL rnd%0d_wd%0d: got %b want %b", it, j, e[32], exp_wd); end
            if (2 * j + 1 < conv_log.size()) begin
               a = conv_log[2*j]; b = conv_log[2*j+1];
               total++; if (e[31:0] !== {a[15:0], b[15:0]}) begin bad++; $display("FAIL rnd%0d_pair%0d: got %h want %h%h", it, j, e[31:0], a[15:0], b[15:0]); end
            end
         end
         total++; if (err !== 1'b0 || wide_start != 0) begin bad++; $display("FAIL rnd%0d_err_width: err=%b wide=%0d want 0/0", it, err, wide_start); end
      end
      rand_delay = 1'b0;
   endtask

   task automatic test_timeout();
      int s;
      clear_logs();
      silent = 1'b1; en = 1'b1;
      for (int i = 0; i < 20 && start_cyc.size() < 1; i++) tick();
      total++; if (start_cyc.size() < 1) begin bad++; $display("FAIL tmo_start: got 0 starts want 1"); end
      s = (start_cyc.size() > 0) ? start_cyc[0] : cyc;
      en = 1'b0;
      while (cyc < s + TIMEOUT_CYC) tick();
      total++; if (busy !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL tmo_last_wait: busy=%b err=%b want 1/0", busy, err); end
      tick();
      total++; if (busy !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL tmo_expire: busy=%b err=%b want 0/1", busy, err); end
      repeat (5) tick();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %b want 1", err); end
      total++; if (vld_log.size() != 0 || start_cyc.size() != 1) begin bad++; $display("FAIL tmo_quiet: vld=%0d starts=%0d want 0/1", vld_log.size(), start_cyc.size()); end
      silent = 1'b0; rand_delay = 1'b0; fixed_delay = 2; en = 1'b1;
      tick();
      total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_restart: err=%b busy=%b want 0/1", err, busy); end
      en = 1'b0;
      for (int i = 0; i < 200 && busy !== 1'b0; i++) tick();
      repeat (3) tick();
      total++; if (vld_log.size() != 1 || err !== 1'b0) begin bad++; $display("FAIL tmo_recover: vld=%0d err=%b want 1/0", vld_log.size(), err); end
   endtask

   task automatic test_timeout_edge();
      clear_logs();
      rand_delay = 1'b0; fixed_delay = TIMEOUT_CYC; en = 1'b1;
      for (int i = 0; i < 20 && start_cyc.size() < 1; i++) tick();
      en = 1'b0;
      for (int i = 0; i < 3000 && busy !== 1'b0; i++) tick();
      repeat (3) tick();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL edge_err: got %b want 0", err); end
      total++; if (vld_log.size() != 1) begin bad++; $display("FAIL edge_vld: got %0d want 1", vld_log.size()); end
   endtask

   task automatic test_reset_mid_wait();
      clear_logs();
      rand_delay = 1'b0; fixed_delay = 20; en = 1'b1;
      for (int i = 0; i < 20 && start_cyc.size() < 1; i++) tick();
      repeat (3) tick();
      rst = 1'b1; en = 1'b0;
      tick();
      rst = 1'b0;
      total++; if (busy !== 1'b0 || adc_ch !== 1'b0 || adc_start !== 1'b0) begin bad++; $display("FAIL rstw_state: busy=%b ch=%b start=%b want 0/0/0", busy, adc_ch, adc_start); end
      repeat (30) tick();
      total++; if ({adc1dat, adc2dat} !== 32'h0) begin bad++; $display("FAIL rstw_data: got %h%h want 00000000", adc1dat, adc2dat); end
      total++; if (dat_vld !== 1'b0 || win_done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rstw_flags: vld=%b wd=%b err=%b want 0/0/0", dat_vld, win_done, err); end
      total++; if (busy !== 1'b0 || adc_ch !== 1'b0) begin bad++; $display("FAIL rstw_idle: busy=%b ch=%b want 0/0", busy, adc_ch); end
      total++; if (vld_log.size() != 0 || start_cyc.size() != 1) begin bad++; $display("FAIL rstw_stray: vld=%0d starts=%0d want 0/1", vld_log.size(), start_cyc.size()); end
   endtask

   task automatic test_big_window();
      int pos, ncur, nwd;
      clear_logs();
      rand_delay = 1'b0; fixed_delay = 1; use_fixed = 1'b0;
      winlog2 = 4'd15; en = 1'b1;
      for (int i = 0; i < 1000 && vld_log.size() < 10; i++) tick();
      winlog2 = 4'd3;
      for (int i = 0; i < 30000 && vld_log.size() < 1031; i++) tick();
      en = 1'b0;
      for (int i = 0; i < 200 && busy !== 1'b0; i++) tick();
      repeat (3) tick();
      total++; if (vld_log.size() != 1032) begin bad++; $display("FAIL big_vld_count: got %0d want 1032", vld_log.size()); end
      pos = 0; ncur = win_pairs(15); nwd = 0;
      for (int j = 0; j < vld_log.size(); j++) begin
         logic [32:0] e;
         logic [16:0] a, b;
         bit exp_wd;
         e = vld_log[j];
         pos++;
         exp_wd = (pos == ncur);
         if (exp_wd) begin pos = 0; ncur = win_pairs(3); end
         if (e[32]) nwd++;
         total++; if (e[32] !== exp_wd) begin bad++; $display("FAIL big_wd%0d: got %b want %b", j, e[32], exp_wd); end
         if (2 * j + 1 < conv_log.size()) begin
            a = conv_log[2*j]; b = conv_log[2*j+1];
            total++; if (e[31:0] !== {a[15:0], b[15:0]}) begin bad++; $display("FAIL big_pair%0d: got %h want %h%h", j, e[31:0], a[15:0], b[15:0]); end
         end
      end
      total++; if (nwd != 2 || orphan_wd != 0) begin bad++; $display("FAIL big_wd_total: got %0d/%0d want 2/0", nwd, orphan_wd); end
   endtask

   initial begin
      test_reset();
      test_window_basic();
      test_settle();
      test_stop_after_ch1();
      test_random_scan();
      test_timeout();
      test_timeout_edge();
      test_reset_mid_wait();
      test_big_window();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
